fft_seq_ctrl: RTL and testbench

Sequencer for the 32-point radix-2 DIT in-place FFT core. Owns the working sample RAM addressing, the twiddle ROM index, the butterfly issue strobe and the 2-bit write-data select of the complex-sample 4:1 mux. Runs one frame per START: load 32 samples, 5 butterfly stages, unload 32 bins in natural order.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_addr_gen.sv | 28 ++
 rtl/fft_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point radix-2 DIT FFT sequencer and datapath.
package fft_pkg;

    localparam int LOG2N = 5;
    localparam int N     = 1 << LOG2N;
    localparam int NBF   = N / 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_UNLOAD  = 3'd4
    } state_t;

    localparam logic [1:0] SEL_EXT = 2'b00;
    localparam logic [1:0] SEL_BF  = 2'b01;

    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = k[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly operand and twiddle addressing for in-place radix-2 DIT.
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [2:0]       s,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx
);

    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] tw_full;

    // Split j into group and position within the span, then interleave.
    always_comb begin
        span    = LOG2N'(1) << s;
        pos     = {1'b0, j} & (span - 1'b1);
        grp     = {1'b0, j} >> s;
        addr_a  = (grp << (s + 3'd1)) | pos;
        addr_b  = addr_a + span;
        tw_full = pos << (3'(LOG2N - 1) - s);
        tw_idx  = tw_full[LOG2N-2:0];
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the 32-point in-place FFT: load, 5 stages, unload.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for START, counters cleared
// ST_LOAD    | accept 32 samples, written bit-reversed
// ST_COMPUTE | issue one butterfly read per cycle, 16 per stage
// ST_DRAIN   | wait 1+BF_LAT cycles for the stage's last write-back
// ST_UNLOAD  | read bins 0..31 in order, gated by OUT_READY
//
// The external sample write is registered, so the datapath presents the
// sample one cycle after its IN_VALID cycle, together with WR_EN/SEL=00.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int BF_LAT = 3
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             IN_VALID,
    input  logic             OUT_READY,
    output logic             IN_READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       SEL,
    output logic             RD_EN,
    output logic [LOG2N-1:0] RD_ADDR_A,
    output logic [LOG2N-1:0] RD_ADDR_B,
    output logic [LOG2N-2:0] TW_IDX,
    output logic             WR_EN,
    output logic [LOG2N-1:0] WR_ADDR_A,
    output logic [LOG2N-1:0] WR_ADDR_B,
    output logic [2:0]       STAGE,
    output logic             OUT_VALID
);

    localparam int              DW       = (BF_LAT > 0) ? $clog2(BF_LAT + 1) : 1;
    localparam logic [DW-1:0]   DRAIN_LD = DW'(BF_LAT);
    localparam logic [2:0]      S_LAST   = 3'(LOG2N - 1);

    state_t           state_q, state_d;
    logic [LOG2N-1:0] k_q, m_q;
    logic [2:0]       s_q;
    logic [LOG2N-2:0] j_q;
    logic [DW-1:0]    d_q;
    logic             cmp_rd, unl_rd;

    logic [LOG2N-1:0] ag_a, ag_b;
    logic [LOG2N-2:0] ag_tw;

    logic             pipe_vld [BF_LAT+1];
    logic [LOG2N-1:0] pipe_a   [BF_LAT+1];
    logic [LOG2N-1:0] pipe_b   [BF_LAT+1];
    logic             ld_vld_q;
    logic [LOG2N-1:0] ld_addr_q;
    logic             ov_q;

    fft_addr_gen u_addr_gen (
        .s      (s_q),
        .j      (j_q),
        .addr_a (ag_a),
        .addr_b (ag_b),
        .tw_idx (ag_tw)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and read-issue decode.
    always_comb begin
        state_d = state_q;
        cmp_rd  = 1'b0;
        unl_rd  = 1'b0;
        case (state_q)
            ST_IDLE:    if (START) state_d = ST_LOAD;
            ST_LOAD:    if (IN_VALID && k_q == '1) state_d = ST_COMPUTE;
            ST_COMPUTE: begin
                cmp_rd = 1'b1;
                if (j_q == '1) state_d = ST_DRAIN;
            end
            ST_DRAIN:   if (d_q == '0) state_d = (s_q == S_LAST) ? ST_UNLOAD : ST_COMPUTE;
            ST_UNLOAD:  begin
                unl_rd = OUT_READY;
                if (OUT_READY && m_q == '1) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Sample, butterfly, drain and bin counters; drain counts down to zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k_q <= '0;
            m_q <= '0;
            s_q <= '0;
            j_q <= '0;
            d_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    k_q <= '0;
                    m_q <= '0;
                    s_q <= '0;
                    j_q <= '0;
                    d_q <= '0;
                end
                ST_LOAD:    if (IN_VALID) k_q <= k_q + 1'b1;
                ST_COMPUTE: begin
                    j_q <= j_q + 1'b1;
                    if (j_q == '1) d_q <= DRAIN_LD;
                end
                ST_DRAIN: begin
                    if (d_q != '0)          d_q <= d_q - 1'b1;
                    else if (s_q != S_LAST) s_q <= s_q + 1'b1;
                end
                ST_UNLOAD:  if (OUT_READY) m_q <= m_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Write-back pipeline, load write register and unload data-valid flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i <= BF_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_a[i]   <= '0;
                pipe_b[i]   <= '0;
            end
            ld_vld_q  <= 1'b0;
            ld_addr_q <= '0;
            ov_q      <= 1'b0;
        end else begin
            pipe_vld[0] <= cmp_rd;
            pipe_a[0]   <= cmp_rd ? ag_a : '0;
            pipe_b[0]   <= cmp_rd ? ag_b : '0;
            for (int i = 1; i <= BF_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_a[i]   <= pipe_a[i-1];
                pipe_b[i]   <= pipe_b[i-1];
            end
            ld_vld_q  <= (state_q == ST_LOAD) && IN_VALID;
            ld_addr_q <= ((state_q == ST_LOAD) && IN_VALID) ? bitrev5(k_q) : '0;
            ov_q      <= unl_rd;
        end
    end

    assign IN_READY  = (state_q == ST_LOAD);
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = unl_rd && (m_q == '1);
    assign RD_EN     = cmp_rd || unl_rd;
    assign RD_ADDR_A = (state_q == ST_COMPUTE) ? ag_a :
                       (state_q == ST_UNLOAD)  ? m_q  : '0;
    assign RD_ADDR_B = (state_q == ST_COMPUTE) ? ag_b  : '0;
    assign TW_IDX    = (state_q == ST_COMPUTE) ? ag_tw : '0;
    assign STAGE     = (state_q == ST_COMPUTE || state_q == ST_DRAIN) ? s_q : 3'd0;
    assign WR_EN     = ld_vld_q || pipe_vld[BF_LAT];
    assign SEL       = pipe_vld[BF_LAT] ? SEL_BF : SEL_EXT;
    assign WR_ADDR_A = pipe_vld[BF_LAT] ? pipe_a[BF_LAT] : ld_addr_q;
    assign WR_ADDR_B = pipe_b[BF_LAT];
    assign OUT_VALID = ov_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl with a behavioural RAM/butterfly model.
module tb_fft_seq_ctrl;
    import fft_pkg::*;

    logic       CLK = 1'b0;
    logic       RST, START, IN_VALID, OUT_READY;
    logic       IN_READY, BUSY, DONE, RD_EN, WR_EN, OUT_VALID;
    logic [1:0] SEL;
    logic [4:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
    logic [3:0] TW_IDX;
    logic [2:0] STAGE;

    int errors = 0;
    int checks = 0;

    fft_seq_ctrl #(.BF_LAT(3)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID),
        .OUT_READY(OUT_READY), .IN_READY(IN_READY), .BUSY(BUSY), .DONE(DONE),
        .SEL(SEL), .RD_EN(RD_EN), .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
        .TW_IDX(TW_IDX), .WR_EN(WR_EN), .WR_ADDR_A(WR_ADDR_A),
        .WR_ADDR_B(WR_ADDR_B), .STAGE(STAGE), .OUT_VALID(OUT_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] rev5(input int k);
        logic [4:0] v, r;
        v = 5'(k);
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    // RAM + butterfly model. Twiddles are not applied: with an impulse at
    // sample 0 every bottom operand is zero, so a+b / a-b is exact.
    int mem [32];
    int qa[$], qb[$];
    int pend [32];
    int ld_cnt = 0, ld_err = 0, ld_total = 0;
    int hz_err = 0, stale = 0, nr_err = 0, ov_err = 0, ord_err = 0;
    int bins_ok = 0, done_cnt = 0, bin_exp = 0;
    int rd_val = 0;
    logic rd_prev = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < 32; i++) pend[i] = 0;
            ld_cnt  = 0;
            bin_exp = 0;
            rd_prev = 1'b0;
        end else begin
            if (OUT_VALID !== rd_prev) ov_err++;
            if (rd_prev && rd_val == 1) bins_ok++;
            rd_prev = 1'b0;
            if (RD_EN && RD_ADDR_B != 5'd0) begin
                if (pend[RD_ADDR_A] != 0 || pend[RD_ADDR_B] != 0) hz_err++;
                qa.push_back(mem[RD_ADDR_A]);
                qb.push_back(mem[RD_ADDR_B]);
                pend[RD_ADDR_A]++;
                pend[RD_ADDR_B]++;
            end else if (RD_EN) begin
                if (!OUT_READY) nr_err++;
                if (int'(RD_ADDR_A) != bin_exp) ord_err++;
                bin_exp = (bin_exp + 1) % 32;
                rd_val  = mem[RD_ADDR_A];
                rd_prev = 1'b1;
            end
            if (DONE) done_cnt++;
            if (WR_EN && SEL == SEL_BF) begin
                if (qa.size() == 0) begin
                    stale++;
                end else begin
                    int a, b;
                    a = qa.pop_front();
                    b = qb.pop_front();
                    mem[WR_ADDR_A] = a + b;
                    mem[WR_ADDR_B] = a - b;
                    pend[WR_ADDR_A]--;
                    pend[WR_ADDR_B]--;
                end
            end else if (WR_EN) begin
                if (WR_ADDR_A != rev5(ld_cnt)) ld_err++;
                mem[WR_ADDR_A] = (ld_cnt == 0) ? 1 : 0;
                ld_cnt++;
                ld_total++;
            end
            if (!BUSY) begin
                ld_cnt  = 0;
                bin_exp = 0;
            end
        end
    end

    int s_ld, s_ldt, s_hz, s_st, s_nr, s_ov, s_ord, s_bins, s_done;

    task automatic snap();
        s_ld = ld_err; s_ldt = ld_total; s_hz = hz_err; s_st = stale; s_nr = nr_err;
        s_ov = ov_err; s_ord = ord_err; s_bins = bins_ok; s_done = done_cnt;
    endtask

    task automatic frame_checks(input string f);
        check({f, " load_order_err"}, 32'(ld_err - s_ld), 0);
        check({f, " load_writes"}, 32'(ld_total - s_ldt), 32);
        check({f, " hazard_err"}, 32'(hz_err - s_hz), 0);
        check({f, " stale_writes"}, 32'(stale - s_st), 0);
        check({f, " read_not_ready"}, 32'(nr_err - s_nr), 0);
        check({f, " out_valid_align"}, 32'(ov_err - s_ov), 0);
        check({f, " bin_order_err"}, 32'(ord_err - s_ord), 0);
        check({f, " bins_equal_one"}, 32'(bins_ok - s_bins), 32);
        check({f, " done_pulses"}, 32'(done_cnt - s_done), 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 99;
        RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst BUSY", 32'(BUSY), 0);
        check("rst WR_EN", 32'(WR_EN), 0);
        check("rst RD_EN", 32'(RD_EN), 0);
        check("rst SEL", 32'(SEL), 0);
        check("rst STAGE", 32'(STAGE), 0);
        check("rst IN_READY", 32'(IN_READY), 0);
        check("rst OUT_VALID", 32'(OUT_VALID), 0);
        RST = 1'b0;
        snap();

        // Frame 1: OUT_READY toggles during unload, stray START/IN_VALID/OUT_READY.
        for (int c = 0; c <= 197; c++) begin
            @(posedge CLK); #1;
            START     = (c == 0 || c == 34);
            IN_VALID  = (c >= 1 && c <= 32) || (c >= 40 && c <= 45);
            OUT_READY = (c >= 133) ? ((c - 133) % 2 == 0) : (c >= 100 && c < 110);
            #1;
            case (c)
                0:   begin check("f1 c0 IN_READY", 32'(IN_READY), 0); check("f1 c0 BUSY", 32'(BUSY), 0); end
                1:   begin check("f1 c1 IN_READY", 32'(IN_READY), 1); check("f1 c1 BUSY", 32'(BUSY), 1); end
                32:  check("f1 c32 IN_READY", 32'(IN_READY), 1);
                33:  begin
                    check("f1 c33 IN_READY", 32'(IN_READY), 0);
                    check("f1 c33 RD_EN", 32'(RD_EN), 1);
                    check("f1 c33 RD_ADDR_B", 32'(RD_ADDR_B), 1);
                end
                35:  begin check("f1 start_ignored IN_READY", 32'(IN_READY), 0); check("f1 c35 BUSY", 32'(BUSY), 1); end
                38:  begin
                    check("s0j5 A", 32'(RD_ADDR_A), 10);
                    check("s0j5 B", 32'(RD_ADDR_B), 11);
                    check("s0j5 TW", 32'(TW_IDX), 0);
                end
                48:  begin check("s0j15 A", 32'(RD_ADDR_A), 30); check("s0j15 B", 32'(RD_ADDR_B), 31); end
                49:  begin check("drain RD_EN", 32'(RD_EN), 0); check("drain STAGE", 32'(STAGE), 0); end
                51:  check("drain c51 WR_EN", 32'(WR_EN), 1);
                52:  begin
                    check("last wb WR_EN", 32'(WR_EN), 1);
                    check("last wb SEL", 32'(SEL), 1);
                    check("last wb WR_ADDR_A", 32'(WR_ADDR_A), 30);
                    check("last wb WR_ADDR_B", 32'(WR_ADDR_B), 31);
                    check("last wb RD_EN", 32'(RD_EN), 0);
                end
                53:  begin
                    check("s1j0 RD_EN", 32'(RD_EN), 1);
                    check("s1j0 STAGE", 32'(STAGE), 1);
                    check("s1j0 A", 32'(RD_ADDR_A), 0);
                    check("s1j0 B", 32'(RD_ADDR_B), 2);
                end
                78:  begin
                    check("s2j5 STAGE", 32'(STAGE), 2);
                    check("s2j5 A", 32'(RD_ADDR_A), 9);
                    check("s2j5 B", 32'(RD_ADDR_B), 13);
                    check("s2j5 TW", 32'(TW_IDX), 4);
                end
                128: begin
                    check("s4j15 STAGE", 32'(STAGE), 4);
                    check("s4j15 A", 32'(RD_ADDR_A), 15);
                    check("s4j15 B", 32'(RD_ADDR_B), 31);
                    check("s4j15 TW", 32'(TW_IDX), 15);
                end
                133: begin
                    check("unl m0 RD_EN", 32'(RD_EN), 1);
                    check("unl m0 A", 32'(RD_ADDR_A), 0);
                    check("unl STAGE", 32'(STAGE), 0);
                    check("unl WR_EN", 32'(WR_EN), 0);
                end
                134: begin check("unl stall RD_EN", 32'(RD_EN), 0); check("unl c134 OUT_VALID", 32'(OUT_VALID), 1); end
                194: check("unl c194 DONE", 32'(DONE), 0);
                195: begin
                    check("m31 DONE", 32'(DONE), 1);
                    check("m31 A", 32'(RD_ADDR_A), 31);
                    check("m31 RD_EN", 32'(RD_EN), 1);
                end
                196: begin
                    check("post BUSY", 32'(BUSY), 0);
                    check("post OUT_VALID", 32'(OUT_VALID), 1);
                    check("post DONE", 32'(DONE), 0);
                end
                197: check("idle OUT_VALID", 32'(OUT_VALID), 0);
                default: ;
            endcase
        end
        frame_checks("f1");

        // Frame 2: reset asserted during stage 2, butterfly 7.
        for (int c = 0; c <= 80; c++) begin
            @(posedge CLK); #1;
            START     = (c == 0);
            IN_VALID  = (c >= 1 && c <= 32);
            OUT_READY = 1'b0;
            #1;
            if (c == 80) begin
                check("s2j7 STAGE", 32'(STAGE), 2);
                check("s2j7 A", 32'(RD_ADDR_A), 11);
                check("s2j7 B", 32'(RD_ADDR_B), 15);
                check("s2j7 inflight WR_EN", 32'(WR_EN), 1);
            end
        end
        RST = 1'b1;
        #1;
        check("async rst WR_EN", 32'(WR_EN), 0);
        check("async rst BUSY", 32'(BUSY), 0);
        check("async rst STAGE", 32'(STAGE), 0);
        @(posedge CLK); #1;
        check("rst edge WR_EN", 32'(WR_EN), 0);
        check("rst edge BUSY", 32'(BUSY), 0);
        check("rst edge STAGE", 32'(STAGE), 0);
        check("rst edge RD_EN", 32'(RD_EN), 0);
        RST = 1'b0;
        snap();

        // Frame 3: minimum-length frame after the mid-compute reset.
        for (int c = 0; c <= 166; c++) begin
            @(posedge CLK); #1;
            START     = (c == 0);
            IN_VALID  = (c >= 1 && c <= 32);
            OUT_READY = 1'b1;
            #1;
            case (c)
                1:   check("f3 c1 IN_READY", 32'(IN_READY), 1);
                2:   check("f3 c2 WR_EN", 32'(WR_EN), 1);
                33:  check("f3 c33 RD_EN", 32'(RD_EN), 1);
                133: check("f3 c133 unl A", 32'(RD_ADDR_A), 0);
                164: begin check("f3 c164 DONE", 32'(DONE), 1); check("f3 c164 A", 32'(RD_ADDR_A), 31); end
                165: begin check("f3 c165 BUSY", 32'(BUSY), 0); check("f3 c165 OUT_VALID", 32'(OUT_VALID), 1); end
                default: ;
            endcase
        end
        frame_checks("f3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
